led_activity_ctrl: RTL and testbench

Drives the board's green LEDs for the network switch as per-port link/activity indicators plus one heartbeat LED.
- Per-port link and activity inputs are turned into visible link/activity patterns, timed from one shared prescaled tick derived from CLOCK_50.
- Sits between the switch port logic and the LEDG pins; this is the only block that drives LEDG.

---
 rtl/led_ctrl_pkg.sv | 17 +
 rtl/led_blink_fsm.sv | 78 +++++++
 rtl/led_activity_ctrl.sv | 87 ++++++++
 tb/tb_led_activity_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared state type, counter-width helper and LEDG bit map for led_activity_ctrl.
package led_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DARK = 2'd1,
      LIT  = 2'd2
   } led_state_t;

   localparam int HB_LED_IDX = 0;

   // Bits needed to hold 0..max_val; never narrower than one bit.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/led_blink_fsm.sv
// One switch port: turns link/activity into a solid-on LED with DARK/LIT activity blinks.
module led_blink_fsm
   import led_ctrl_pkg::*;
#(
   parameter int OFF_TICKS = 30,
   parameter int ON_TICKS  = 30
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick,
   input  logic link_up,
   input  logic activity,
   output logic led
);

   localparam int DW = cnt_width((OFF_TICKS > ON_TICKS) ? OFF_TICKS : ON_TICKS);
   localparam logic [DW-1:0] OFF_LOAD = DW'(OFF_TICKS);
   localparam logic [DW-1:0] ON_LOAD  = DW'(ON_TICKS);
   localparam logic [DW-1:0] DW_ONE   = DW'(1);

   led_state_t    state_reg;
   logic          pending_reg;
   logic [DW-1:0] dwell_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         pending_reg <= 1'b0;
         dwell_reg   <= '0;
         led         <= 1'b0;
      end else begin
         led <= (state_reg != DARK) && link_up;
         // Link loss overrides everything, including a tick in the same cycle.
         if (!link_up) begin
            state_reg   <= IDLE;
            pending_reg <= 1'b0;
            dwell_reg   <= '0;
         end else begin
            case (state_reg)
               IDLE: begin
                  if (activity || pending_reg) begin
                     state_reg   <= DARK;
                     dwell_reg   <= OFF_LOAD;
                     pending_reg <= 1'b0;
                  end
               end
               DARK: begin
                  pending_reg <= pending_reg | activity;
                  if (tick) begin
                     if (dwell_reg == DW_ONE) begin
                        state_reg <= LIT;
                        dwell_reg <= ON_LOAD;
                     end else begin
                        dwell_reg <= dwell_reg - DW_ONE;
                     end
                  end
               end
               LIT: begin
                  pending_reg <= pending_reg | activity;
                  if (tick) begin
                     if (dwell_reg == DW_ONE) begin
                        state_reg <= IDLE;
                        dwell_reg <= '0;
                     end else begin
                        dwell_reg <= dwell_reg - DW_ONE;
                     end
                  end
               end
               default: begin
                  state_reg <= IDLE;
                  dwell_reg <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/led_activity_ctrl.sv
// Switch LED driver: shared tick prescaler, heartbeat on LEDG[0], one blink FSM per port.
// Optional lamp test input enabled by defining LED_LAMP_TEST_EN.
module led_activity_ctrl
   import led_ctrl_pkg::*;
#(
   parameter int NUM_PORTS = 4,
   parameter int TICK_DIV  = 50000,
   parameter int OFF_TICKS = 30,
   parameter int ON_TICKS  = 30,
   parameter int HB_TICKS  = 500
) (
   input  logic                 CLOCK_50,
   input  logic                 RESET_N,
   input  logic [NUM_PORTS-1:0] link_up,
   input  logic [NUM_PORTS-1:0] activity,
`ifdef LED_LAMP_TEST_EN
   input  logic                 lamp_test,
`endif
   output logic [NUM_PORTS:0]   LEDG
);

   localparam int PW = cnt_width(TICK_DIV - 1);
   localparam int HW = cnt_width(HB_TICKS - 1);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [HW-1:0] HB_LAST    = HW'(HB_TICKS - 1);

   logic [PW-1:0]        presc_reg;
   logic                 tick_reg;
   logic [HW-1:0]        hb_cnt_reg;
   logic                 hb_reg;
   logic [NUM_PORTS-1:0] port_led;
   logic [NUM_PORTS:0]   normal_ledg;

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         presc_reg  <= '0;
         tick_reg   <= 1'b0;
         hb_cnt_reg <= '0;
         hb_reg     <= 1'b0;
      end else begin
         tick_reg  <= (presc_reg == PRESC_LAST);
         presc_reg <= (presc_reg == PRESC_LAST) ? '0 : presc_reg + 1'b1;
         if (tick_reg) begin
            if (hb_cnt_reg == HB_LAST) begin
               hb_cnt_reg <= '0;
               hb_reg     <= ~hb_reg;
            end else begin
               hb_cnt_reg <= hb_cnt_reg + 1'b1;
            end
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
         led_blink_fsm #(
            .OFF_TICKS(OFF_TICKS),
            .ON_TICKS (ON_TICKS)
         ) u_fsm (
            .clk     (CLOCK_50),
            .rst_n   (RESET_N),
            .tick    (tick_reg),
            .link_up (link_up[gi]),
            .activity(activity[gi]),
            .led     (port_led[gi])
         );
      end
   endgenerate

   assign normal_ledg[HB_LED_IDX]  = hb_reg;
   assign normal_ledg[NUM_PORTS:1] = port_led;

`ifdef LED_LAMP_TEST_EN
   logic lamp_reg;

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) lamp_reg <= 1'b0;
      else          lamp_reg <= lamp_test;
   end

   // Forcing happens at the output only; the FSMs keep running underneath.
   assign LEDG = lamp_reg ? '1 : normal_ledg;
`else
   assign LEDG = normal_ledg;
`endif

endmodule

// File: tb/tb_led_activity_ctrl.sv
// Directed bench for led_activity_ctrl with small timing parameters.
module tb_led_activity_ctrl;

   localparam int NP        = 4;
   localparam int TD        = 4;
   localparam int OT        = 2;
   localparam int NT        = 2;
   localparam int HB        = 3;
   localparam int HB_PERIOD = HB * TD;

   logic          CLOCK_50 = 1'b0;
   logic          RESET_N;
   logic [NP-1:0] link_up;
   logic [NP-1:0] activity;
`ifdef LED_LAMP_TEST_EN
   logic          lamp_test;
`endif
   logic [NP:0]   LEDG;

   int total = 0;
   int bad   = 0;
   int edges;

   typedef struct {
      logic [3:0] link;
      logic [3:0] act;
      logic [3:0] exp_port;
   } vec_t;

   vec_t vecs[$];

   led_activity_ctrl #(
      .NUM_PORTS(NP),
      .TICK_DIV (TD),
      .OFF_TICKS(OT),
      .ON_TICKS (NT),
      .HB_TICKS (HB)
   ) dut (
      .CLOCK_50(CLOCK_50),
      .RESET_N (RESET_N),
      .link_up (link_up),
      .activity(activity),
`ifdef LED_LAMP_TEST_EN
      .lamp_test(lamp_test),
`endif
      .LEDG    (LEDG)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   // Rising edges since the last reset release.
   always @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) edges <= 0;
      else          edges <= edges + 1;
   end

   // Heartbeat toggles on edges 13, 25, 37, ... after release.
   function automatic logic hb_exp();
      if (edges < 1) return 1'b0;
      return (((edges - 1) / HB_PERIOD) % 2) == 1;
   endfunction

   task automatic check(input string name, input logic [NP:0] got, input logic [NP:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: LEDG=%b expected %b (edge %0d)", name, got, want, edges);
      end else begin
         $display("ok   %s: LEDG=%b (edge %0d)", name, got, edges);
      end
   endtask

   task automatic add(input logic [3:0] link, input logic [3:0] act,
                      input logic [3:0] exp_port, input int count);
      vec_t v;
      v.link     = link;
      v.act      = act;
      v.exp_port = exp_port;
      for (int i = 0; i < count; i++) vecs.push_back(v);
   endtask

   task automatic step();
      @(negedge CLOCK_50);
   endtask

   initial begin
      // Row i drives edge 26+i; ticks are consumed at edges 29, 33, 37, ...
      add(4'b0101, 4'b0000, 4'b0101, 2);   // link only: ports 0 and 2 solid
      add(4'b0101, 4'b0011, 4'b0101, 1);   // port0 pulse; port1 pulse without link ignored
      add(4'b0101, 4'b0000, 4'b0100, 5);   // port0 DARK for two ticks
      add(4'b0101, 4'b0000, 4'b0101, 4);   // LIT
      add(4'b0101, 4'b0001, 4'b0101, 1);   // pulse during LIT -> pending
      add(4'b0101, 4'b0000, 4'b0101, 4);   // LIT ends at edge 41, DARK at 42
      add(4'b0101, 4'b0000, 4'b0100, 7);   // second blink from pending
      add(4'b0101, 4'b0000, 4'b0101, 10);  // LIT then IDLE, no third blink

      RESET_N  = 1'b0;
      link_up  = '0;
      activity = '0;
`ifdef LED_LAMP_TEST_EN
      lamp_test = 1'b0;
`endif
      repeat (3) step();
      check("reset_state", LEDG, 5'b00000);
      RESET_N = 1'b1;
      link_up = 4'b1111;
      repeat (10) step();
      check("links_before_reset", LEDG, {4'b1111, hb_exp()});

      #2 RESET_N = 1'b0;
      link_up = '0;
      #1 check("async_reset", LEDG, 5'b00000);
      step();
      check("held_in_reset", LEDG, 5'b00000);
      RESET_N = 1'b1;

      repeat (12) step();
      check("hb_edge12", LEDG, 5'b00000);
      step();
      check("hb_edge13", LEDG, 5'b00001);
      repeat (11) step();
      check("hb_edge24", LEDG, 5'b00001);
      step();
      check("hb_edge25", LEDG, 5'b00000);

      foreach (vecs[i]) begin
         link_up  = vecs[i].link;
         activity = vecs[i].act;
         step();
         check($sformatf("vec%0d", i), LEDG, {vecs[i].exp_port, hb_exp()});
      end

      // Port 2 enters DARK at edge 60; link drops at edge 65, coinciding with a tick.
      link_up  = 4'b0101;
      activity = 4'b0100;
      step();
      check("drop_pulse", LEDG, {4'b0101, hb_exp()});
      for (int i = 0; i < 4; i++) begin
         activity = (i == 2) ? 4'b0100 : 4'b0000;
         step();
         check($sformatf("drop_dark%0d", i), LEDG, {4'b0001, hb_exp()});
      end
      link_up = 4'b0001;
      for (int i = 0; i < 4; i++) begin
         activity = (i == 1) ? 4'b0100 : 4'b0000;
         step();
         check($sformatf("drop_down%0d", i), LEDG, {4'b0001, hb_exp()});
      end
      link_up  = 4'b0101;
      activity = 4'b0000;
      for (int i = 0; i < 12; i++) begin
         step();
         check($sformatf("relink%0d", i), LEDG, {4'b0101, hb_exp()});
      end

      link_up = 4'b0000;
`ifdef LED_LAMP_TEST_EN
      lamp_test = 1'b1;
      step();
      check("lamp_on", LEDG, 5'b11111);
      lamp_test = 1'b0;
      step();
      check("lamp_off", LEDG, {4'b0000, hb_exp()});
`else
      step();
      check("all_links_down", LEDG, {4'b0000, hb_exp()});
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
